// File: rtl/scan_chain_ctrl.sv
// Serial load/capture sequencer for an external chain of hold/load select flops.
// Optional parity self-check is enabled by defining SCAN_PARITY_EN.
module scan_chain_ctrl #(
    parameter int CHAIN_LEN = 8,
    parameter int CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] load_data,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] capture_data,
    output logic                 chain_sel,
    output logic                 chain_din,
    input  logic                 chain_dout
`ifdef SCAN_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

    generate
        if (CHAIN_LEN < 2 || (2 ** CNT_W) <= CHAIN_LEN) begin : g_bad_params
            $error("scan_chain_ctrl: CHAIN_LEN must be >= 2 and 2**CNT_W > CHAIN_LEN");
        end
    endgenerate

    logic [1:0]           r_state;
    logic [CHAIN_LEN-1:0] r_shreg;
    logic [CHAIN_LEN-1:0] r_capture;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_sel;
    logic [CHAIN_LEN-1:0] w_shreg_nxt;
    logic                 w_last;

    assign w_shreg_nxt = {chain_dout, r_shreg[CHAIN_LEN-1:1]};
    assign w_last      = (r_cnt == CNT_LAST);

    // Gated by select so the serial line is quiet whenever the chain holds.
    assign chain_din    = r_sel & r_shreg[0];
    assign chain_sel    = r_sel;
    assign busy         = r_busy;
    assign done         = r_done;
    assign capture_data = r_capture;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_shreg   <= '0;
            r_capture <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sel     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shreg <= load_data;
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                        r_sel   <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    r_shreg <= w_shreg_nxt;
                    if (w_last) begin
                        // Capture the post-shift word so it is valid alongside done.
                        r_capture <= w_shreg_nxt;
                        r_cnt     <= '0;
                        r_state   <= S_DONE;
                        r_sel     <= 1'b0;
                        r_done    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_sel   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SCAN_PARITY_EN
    logic r_par;
    logic r_perr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_par  <= 1'b0;
            r_perr <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_par <= ^load_data;
        end else if (r_state == S_SHIFT && w_last) begin
            r_perr <= (^w_shreg_nxt) ^ r_par;
        end
    end

    assign parity_err = r_perr;
`endif

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Scoreboard bench for scan_chain_ctrl driving a modelled 8-flop external chain.
module tb_scan_chain_ctrl;

    typedef struct {
        logic [7:0] cap;
        logic       perr;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic       busy, done, chain_sel, chain_din, chain_dout;
    logic [7:0] capture_data;
    logic       parity_err;
    logic       inj = 1'b0;

    // cq[0] is the flop driving chain_dout; new bits enter at cq[7].
    logic [7:0] cq = 8'h00;

    int   tests = 0;
    int   fails = 0;
    logic din_q[$];
    exp_t cap_q[$];

    always #5 clk = ~clk;

    scan_chain_ctrl #(.CHAIN_LEN(8), .CNT_W(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .load_data    (load_data),
        .busy         (busy),
        .done         (done),
        .capture_data (capture_data),
        .chain_sel    (chain_sel),
        .chain_din    (chain_din),
        .chain_dout   (chain_dout)
`ifdef SCAN_PARITY_EN
        ,
        .parity_err   (parity_err)
`endif
    );

`ifndef SCAN_PARITY_EN
    assign parity_err = 1'b0;
`endif

    always @(posedge clk) if (chain_sel) cq <= {chain_din, cq[7:1]};
    assign chain_dout = cq[0] ^ inj;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: serial bits while selecting, captured word on done.
    always @(negedge clk) begin
        if (reset_n) begin
            if (chain_sel) begin
                if (din_q.size() == 0) chk("din_unexpected", 32'(chain_din), 32'hx);
                else chk("chain_din", 32'(chain_din), 32'(din_q.pop_front()));
            end
            if (done) begin
                if (cap_q.size() == 0) chk("done_unexpected", 32'(capture_data), 32'hx);
                else begin
                    exp_t e;
                    e = cap_q.pop_front();
                    chk("capture_data", 32'(capture_data), 32'(e.cap));
`ifdef SCAN_PARITY_EN
                    chk("parity_err", 32'(parity_err), 32'(e.perr));
`endif
                end
            end
        end
    end

    task automatic push(input logic [7:0] data, input logic [7:0] cap, input logic perr);
        exp_t e;
        for (int i = 0; i < 8; i++) din_q.push_back(data[i]);
        e.cap  = cap;
        e.perr = perr;
        cap_q.push_back(e);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (busy) chk("idle_timeout", 32'(busy), 32'h0);
    endtask

    task automatic xfer(input logic [7:0] data, input logic [7:0] cap, input logic perr,
                        input logic [7:0] chain_exp, input int inj_cyc);
        int n;
        wait_idle();
        @(negedge clk);
        start     = 1'b1;
        load_data = data;
        push(data, cap, perr);
        @(negedge clk);
        start     = 1'b0;
        load_data = ~data;
        n   = 1;
        inj = (n == inj_cyc);
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
            inj = (n == inj_cyc);
        end
        inj = 1'b0;
        chk("done_latency", 32'(n), 32'd9);
        @(negedge clk);
        chk("chain_contents", 32'(cq), 32'(chain_exp));
        chk("busy_after", 32'(busy), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int dones, done_at, d1, d2;
        #1;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_sel", 32'(chain_sel), 32'h0);
        chk("rst_din", 32'(chain_din), 32'h0);
        chk("rst_capture", 32'(capture_data), 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        xfer(8'hA5, 8'h00, 1'b0, 8'hA5, 0);
        xfer(8'h3C, 8'hA5, 1'b0, 8'h3C, 0);

        // Starts in a SHIFT cycle and in the DONE cycle are dropped.
        wait_idle();
        @(negedge clk);
        start = 1'b1;
        load_data = 8'h96;
        push(8'h96, 8'h3C, 1'b0);
        dones = 0;
        done_at = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                done_at = n;
            end
            start = (n == 3 || n == 9);
            load_data = 8'hFF;
            if (n == 10) chk("busy_cycle10", 32'(busy), 32'h0);
        end
        chk("ignored_dones", 32'(dones), 32'd1);
        chk("ignored_done_at", 32'(done_at), 32'd9);
        chk("no_queueing", 32'(busy), 32'h0);
        chk("chain_96", 32'(cq), 32'h96);

        // Reset in SHIFT cycle 4: three shifts have landed, chain must freeze.
        @(negedge clk);
        start = 1'b1;
        load_data = 8'h11;
        for (int i = 0; i < 8; i++) din_q.push_back(load_data[i]);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        chk("abort_sel", 32'(chain_sel), 32'h0);
        chk("abort_din", 32'(chain_din), 32'h0);
        chk("abort_capture", 32'(capture_data), 32'h0);
        din_q.delete();
        repeat (3) @(negedge clk);
        chk("abort_chain_frozen", 32'(cq), 32'h32);
        reset_n = 1'b1;
        @(negedge clk);
        xfer(8'hFF, 8'h32, 1'b0, 8'hFF, 0);

        // start held high: transfers every 10 cycles.
        wait_idle();
        @(negedge clk);
        start = 1'b1;
        load_data = 8'h0F;
        push(8'h0F, 8'hFF, 1'b0);
        push(8'h0F, 8'h0F, 1'b0);
        d1 = 0;
        d2 = 0;
        for (int n = 1; n <= 21; n++) begin
            @(negedge clk);
            if (done) begin
                if (d1 == 0) d1 = n;
                else d2 = n;
            end
            if (n == 10) chk("b2b_idle_gap", 32'(busy), 32'h0);
            if (n == 11) start = 1'b0;
        end
        chk("b2b_first_done", 32'(d1), 32'd9);
        chk("b2b_second_done", 32'(d2), 32'd19);
        chk("b2b_chain", 32'(cq), 32'h0F);

`ifdef SCAN_PARITY_EN
        xfer(8'h5A, 8'h0F, 1'b0, 8'h5A, 0);
        xfer(8'h5A, 8'h5A, 1'b0, 8'h5A, 0);
        // Corrupt the bit leaving the chain in SHIFT cycle 4 -> capture bit 3.
        xfer(8'h5A, 8'h52, 1'b1, 8'h5A, 4);
        @(negedge clk);
        chk("parity_err_hold", 32'(parity_err), 32'h1);
`endif

        repeat (2) @(negedge clk);
        chk("din_queue_empty", 32'(din_q.size()), 32'h0);
        chk("cap_queue_empty", 32'(cap_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
